// File: rtl/cmd_trigger_gate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cmd_trigger_gate_pkg                                      |
// | Brief    : Shared types and default widths for the trigger gate.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package cmd_trigger_gate_pkg;

  localparam int DEF_DELAY_WIDTH = 8;
  localparam int DEF_DEAD_WIDTH  = 8;
  localparam int DEF_CNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_FIRE  = 2'd2,
    ST_DEAD  = 2'd3
  } trig_state_t;

  // Width of the shared delay/dead-time counter.
  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_trigger_gate_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cmd_trigger_gate_if                                       |
// | Brief    : Trigger, gating, configuration and status bundle between  |
// |            the sequencer side (master) and the trigger gate (slave). |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface cmd_trigger_gate_if import cmd_trigger_gate_pkg::*; #(
  parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter int DEAD_WIDTH  = DEF_DEAD_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
);
  logic                   TRIGGER_IN;
  logic                   TRIG_INVERT;
  logic [DELAY_WIDTH-1:0] TRIG_DELAY;
  logic [DEAD_WIDTH-1:0]  TRIG_DEAD_TIME;
  logic                   CMD_EXT_START_ENABLE;
  logic                   CMD_READY;
  logic                   CNT_CLR;
  logic                   CMD_EXT_START_FLAG;
  logic                   TRIG_BUSY;
  logic [CNT_WIDTH-1:0]   TRIG_ACCEPT_CNT;
  logic [CNT_WIDTH-1:0]   TRIG_VETO_CNT;

  modport master (
    output TRIGGER_IN, TRIG_INVERT, TRIG_DELAY, TRIG_DEAD_TIME,
           CMD_EXT_START_ENABLE, CMD_READY, CNT_CLR,
    input  CMD_EXT_START_FLAG, TRIG_BUSY, TRIG_ACCEPT_CNT, TRIG_VETO_CNT
  );

  modport slave (
    input  TRIGGER_IN, TRIG_INVERT, TRIG_DELAY, TRIG_DEAD_TIME,
           CMD_EXT_START_ENABLE, CMD_READY, CNT_CLR,
    output CMD_EXT_START_FLAG, TRIG_BUSY, TRIG_ACCEPT_CNT, TRIG_VETO_CNT
  );
endinterface
`default_nettype wire

// File: rtl/cmd_trigger_gate_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cmd_trigger_sync                                          |
// | Brief    : Polarity select, 2-FF synchroniser, history register and  |
// |            single-cycle active-edge detect for the external trigger. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cmd_trigger_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_trigger,
  input  logic i_invert,
  output logic o_edge
);
  logic w_trig_pol;
  logic r_s1;
  logic r_s2;
  logic r_s3;

  assign w_trig_pol = i_trigger ^ i_invert;

  // Synchronise the polarity-corrected trigger and keep one cycle of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= w_trig_pol;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // A low history register at reset release lets an already-active input count as an edge.
  assign o_edge = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/cmd_trigger_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cmd_trigger_gate                                          |
// | Brief    : External trigger conditioner: edge detect, programmable   |
// |            delay and dead time, gating by enable/ready, one-cycle    |
// |            start flag, accepted/vetoed event counters.               |
// | Config   : CMD_TRIG_COUNTERS_EN - define to build the event counters;|
// |            undefined ties both counts to 0 and ignores CNT_CLR.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cmd_trigger_gate import cmd_trigger_gate_pkg::*; #(
  parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter int DEAD_WIDTH  = DEF_DEAD_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input logic               CMD_CLK,
  input logic               CMD_RST_N,
  cmd_trigger_gate_if.slave bus
);
  localparam int TMR_WIDTH = max_width(DELAY_WIDTH, DEAD_WIDTH);

  trig_state_t          r_state;
  trig_state_t          w_next_state;
  logic [TMR_WIDTH-1:0] r_timer;
  logic [TMR_WIDTH-1:0] w_delay_load;
  logic [TMR_WIDTH-1:0] w_dead_load;
  logic                 w_trig_edge;
  logic                 w_load_delay;
  logic                 w_load_dead;
  logic                 w_acc_inc;
  logic                 w_veto_inc;
  logic                 w_flag_d;
  logic                 w_busy_d;
  logic                 r_flag;
  logic                 r_busy;

  cmd_trigger_sync u_sync (
    .clk       (CMD_CLK),
    .rst_n     (CMD_RST_N),
    .i_trigger (bus.TRIGGER_IN),
    .i_invert  (bus.TRIG_INVERT),
    .o_edge    (w_trig_edge)
  );

  // Counter preload is N-1 because the transition happens on the cycle the counter reads 0.
  assign w_delay_load = TMR_WIDTH'(bus.TRIG_DELAY) - TMR_WIDTH'(1);
  assign w_dead_load  = TMR_WIDTH'(bus.TRIG_DEAD_TIME) - TMR_WIDTH'(1);

  // State register.
  always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
    if (!CMD_RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, counter-load and event decode.
  always_comb begin
    w_next_state = r_state;
    w_load_delay = 1'b0;
    w_load_dead  = 1'b0;
    w_acc_inc    = 1'b0;
    w_veto_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig_edge) begin
          if (bus.CMD_EXT_START_ENABLE && bus.CMD_READY) begin
            w_acc_inc = 1'b1;
            if (bus.TRIG_DELAY == '0) begin
              w_next_state = ST_FIRE;
            end else begin
              w_next_state = ST_DELAY;
              w_load_delay = 1'b1;
            end
          end else begin
            w_veto_inc = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        w_veto_inc = w_trig_edge;
        // Losing the enable abandons the pending start; the accept count stays.
        if (!bus.CMD_EXT_START_ENABLE) begin
          w_next_state = ST_IDLE;
        end else if (r_timer == '0) begin
          w_next_state = ST_FIRE;
        end
      end
      ST_FIRE: begin
        w_veto_inc = w_trig_edge;
        if (bus.TRIG_DEAD_TIME == '0) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DEAD;
          w_load_dead  = 1'b1;
        end
      end
      ST_DEAD: begin
        w_veto_inc = w_trig_edge;
        if (r_timer == '0) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs align with the state.
  always_comb begin
    w_flag_d = (w_next_state == ST_FIRE);
    w_busy_d = (w_next_state != ST_IDLE);
  end

  // Registered outputs.
  always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
    if (!CMD_RST_N) begin
      r_flag <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_flag <= w_flag_d;
      r_busy <= w_busy_d;
    end
  end

  // Shared delay / dead-time down-counter.
  always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
    if (!CMD_RST_N) begin
      r_timer <= '0;
    end else if (w_load_delay) begin
      r_timer <= w_delay_load;
    end else if (w_load_dead) begin
      r_timer <= w_dead_load;
    end else if ((r_state == ST_DELAY || r_state == ST_DEAD) && r_timer != '0) begin
      r_timer <= r_timer - TMR_WIDTH'(1);
    end
  end

  assign bus.CMD_EXT_START_FLAG = r_flag;
  assign bus.TRIG_BUSY          = r_busy;

`ifdef CMD_TRIG_COUNTERS_EN
  logic [CNT_WIDTH-1:0] r_accept_cnt;
  logic [CNT_WIDTH-1:0] r_veto_cnt;

  // Saturating event counters; a clear wins over a same-cycle increment.
  always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
    if (!CMD_RST_N) begin
      r_accept_cnt <= '0;
      r_veto_cnt   <= '0;
    end else if (bus.CNT_CLR) begin
      r_accept_cnt <= '0;
      r_veto_cnt   <= '0;
    end else begin
      if (w_acc_inc && (r_accept_cnt != '1)) begin
        r_accept_cnt <= r_accept_cnt + CNT_WIDTH'(1);
      end
      if (w_veto_inc && (r_veto_cnt != '1)) begin
        r_veto_cnt <= r_veto_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.TRIG_ACCEPT_CNT = r_accept_cnt;
  assign bus.TRIG_VETO_CNT   = r_veto_cnt;
`else
  logic w_cnt_unused;

  assign w_cnt_unused        = bus.CNT_CLR | w_acc_inc | w_veto_inc;
  assign bus.TRIG_ACCEPT_CNT = '0;
  assign bus.TRIG_VETO_CNT   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmd_trigger_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_cmd_trigger_gate                                       |
// | Brief    : Self-checking bench for cmd_trigger_gate. Expected flag   |
// |            cycles are queued when a trigger is driven and matched    |
// |            when the flag appears; counts come from a small model.    |
// | Config   : CMD_TRIG_COUNTERS_EN selects whether counts are modelled. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_cmd_trigger_gate;

`ifdef CMD_TRIG_COUNTERS_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   errors = 0;
  int   checks = 0;
  int   exp_acc = 0;
  int   exp_veto = 0;
  int   exp_q[$];

  cmd_trigger_gate_if #(.DELAY_WIDTH(8), .DEAD_WIDTH(8), .CNT_WIDTH(CW)) bus ();

  cmd_trigger_gate #(.DELAY_WIDTH(8), .DEAD_WIDTH(8), .CNT_WIDTH(CW)) dut (
    .CMD_CLK   (clk),
    .CMD_RST_N (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Number of rising clock edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic chk_counts(input string tag);
    chk({tag, "_accept"}, 32'(bus.TRIG_ACCEPT_CNT), CNT_ON ? exp_acc : 0);
    chk({tag, "_veto"},   32'(bus.TRIG_VETO_CNT),   CNT_ON ? exp_veto : 0);
  endtask

  // Scoreboard side: every flag must match the oldest queued expected cycle.
  always @(negedge clk) begin
    if (bus.CMD_EXT_START_FLAG === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("flag_unexpected", 32'(bus.CMD_EXT_START_FLAG), 0);
      end else begin
        chk("flag_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.TRIGGER_IN           = 1'b0;
    bus.TRIG_INVERT          = 1'b0;
    bus.TRIG_DELAY           = 8'd0;
    bus.TRIG_DEAD_TIME       = 8'd0;
    bus.CMD_EXT_START_ENABLE = 1'b1;
    bus.CMD_READY            = 1'b1;
    bus.CNT_CLR              = 1'b0;
    #2 rst_n = 1'b0;

    // Reset state.
    tick(3);
    chk("rst_flag", 32'(bus.CMD_EXT_START_FLAG), 0);
    chk("rst_busy", 32'(bus.TRIG_BUSY), 0);
    chk_counts("rst");
    rst_n = 1'b1;
    tick(3);

    // Basic accept, no delay, no dead time: flag at n+3.
    exp_q.push_back(cyc + 3);
    exp_acc = sat_inc(exp_acc);
    bus.TRIGGER_IN = 1'b1;
    tick(5);
    bus.TRIGGER_IN = 1'b0;
    tick(5);
    chk("basic_busy", 32'(bus.TRIG_BUSY), 0);
    chk_counts("basic");

    // Delay 5, dead 10: flag at n+8, edge 6 cycles later vetoed.
    bus.TRIG_DELAY     = 8'd5;
    bus.TRIG_DEAD_TIME = 8'd10;
    exp_q.push_back(cyc + 8);
    exp_acc = sat_inc(exp_acc);
    bus.TRIGGER_IN = 1'b1;
    tick(4);
    chk("delay_busy", 32'(bus.TRIG_BUSY), 1);
    tick(1);
    bus.TRIGGER_IN = 1'b0;
    tick(6);
    exp_veto = sat_inc(exp_veto);
    bus.TRIGGER_IN = 1'b1;
    tick(4);
    bus.TRIGGER_IN = 1'b0;
    for (int i = 0; i < 40 && bus.TRIG_BUSY !== 1'b0; i++) tick(1);
    chk("dead_busy_fall", 32'(bus.TRIG_BUSY), 0);
    chk_counts("dead_veto");
    exp_q.push_back(cyc + 8);
    exp_acc = sat_inc(exp_acc);
    bus.TRIGGER_IN = 1'b1;
    tick(4);
    bus.TRIGGER_IN = 1'b0;
    tick(25);
    chk_counts("after_dead");

    // Gating: ready low vetoes three edges.
    bus.TRIG_DELAY     = 8'd0;
    bus.TRIG_DEAD_TIME = 8'd0;
    bus.CMD_READY      = 1'b0;
    repeat (3) begin
      exp_veto = sat_inc(exp_veto);
      bus.TRIGGER_IN = 1'b1;
      tick(3);
      bus.TRIGGER_IN = 1'b0;
      tick(3);
    end
    chk_counts("ready_low");

    // Enable dropped while in DELAY: abort, no flag, accept kept.
    bus.CMD_READY  = 1'b1;
    bus.TRIG_DELAY = 8'd5;
    exp_acc = sat_inc(exp_acc);
    bus.TRIGGER_IN = 1'b1;
    tick(4);
    chk("abort_busy_before", 32'(bus.TRIG_BUSY), 1);
    bus.CMD_EXT_START_ENABLE = 1'b0;
    tick(2);
    chk("abort_busy_after", 32'(bus.TRIG_BUSY), 0);
    bus.TRIGGER_IN = 1'b0;
    tick(2);
    bus.CMD_EXT_START_ENABLE = 1'b1;
    tick(10);
    chk_counts("abort");

    // Polarity: inverted, falling edge fires, rising edge does not.
    bus.TRIG_DELAY = 8'd0;
    bus.CMD_EXT_START_ENABLE = 1'b0;
    bus.TRIG_INVERT = 1'b1;
    exp_veto = sat_inc(exp_veto);
    tick(5);
    bus.TRIGGER_IN = 1'b1;
    tick(4);
    bus.CMD_EXT_START_ENABLE = 1'b1;
    tick(1);
    exp_q.push_back(cyc + 3);
    exp_acc = sat_inc(exp_acc);
    bus.TRIGGER_IN = 1'b0;
    tick(6);
    bus.TRIGGER_IN = 1'b1;
    tick(6);
    chk_counts("invert");

    // Back to normal polarity (input high gives one vetoed edge), then saturate.
    bus.CMD_EXT_START_ENABLE = 1'b0;
    bus.TRIG_INVERT = 1'b0;
    exp_veto = sat_inc(exp_veto);
    tick(5);
    bus.CMD_EXT_START_ENABLE = 1'b1;
    bus.TRIGGER_IN = 1'b0;
    tick(3);
    repeat (20) begin
      exp_q.push_back(cyc + 3);
      exp_acc = sat_inc(exp_acc);
      bus.TRIGGER_IN = 1'b1;
      tick(3);
      bus.TRIGGER_IN = 1'b0;
      tick(3);
    end
    chk_counts("saturate");

    // Clear on the same cycle as an accept: clear wins.
    exp_q.push_back(cyc + 3);
    bus.TRIGGER_IN = 1'b1;
    tick(2);
    bus.CNT_CLR = 1'b1;
    tick(1);
    bus.CNT_CLR = 1'b0;
    exp_acc  = 0;
    exp_veto = 0;
    tick(3);
    bus.TRIGGER_IN = 1'b0;
    tick(3);
    chk_counts("clear");

    // Reset while in DELAY: everything zero, no flag afterwards.
    bus.TRIG_DELAY = 8'd5;
    bus.TRIGGER_IN = 1'b1;
    tick(4);
    chk("pre_reset_busy", 32'(bus.TRIG_BUSY), 1);
    rst_n = 1'b0;
    exp_acc  = 0;
    exp_veto = 0;
    #1;
    chk("midrst_flag", 32'(bus.CMD_EXT_START_FLAG), 0);
    chk("midrst_busy", 32'(bus.TRIG_BUSY), 0);
    chk_counts("midrst");
    bus.TRIGGER_IN = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(15);
    chk("post_reset_busy", 32'(bus.TRIG_BUSY), 0);
    chk_counts("post_reset");

    chk("pending_flags", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
